// File: rtl/bicubic_lb_if.sv
// Pixel stream, filter weights and filtered-pixel result of the bicubic line-buffer core.
interface bicubic_lb_if;
  logic              ce;
  logic [7:0]        din;
  logic signed [8:0] h_w0;
  logic signed [8:0] h_w1;
  logic signed [8:0] h_w2;
  logic signed [8:0] h_w3;
  logic signed [8:0] v_w0;
  logic signed [8:0] v_w1;
  logic signed [8:0] v_w2;
  logic signed [8:0] v_w3;
  logic [7:0]        pixel_out;
  logic              output_valid;

  modport master (
    output ce, din, h_w0, h_w1, h_w2, h_w3, v_w0, v_w1, v_w2, v_w3,
    input  pixel_out, output_valid
  );

  modport slave (
    input  ce, din, h_w0, h_w1, h_w2, h_w3, v_w0, v_w1, v_w2, v_w3,
    output pixel_out, output_valid
  );
endinterface

// File: rtl/bicubic_lb_core.sv
// Separable 4x4 bicubic filter: three-row line buffer, 4x4 window, horizontal MAC
// stage, then vertical MAC with rounding and clamp to an 8-bit pixel.
module bicubic_lb_core #(
  parameter int IMG_WIDTH = 128
) (
  input logic       clk,
  input logic       rst,
  bicubic_lb_if.slave bus
);

  localparam int LB_DEPTH = 3 * IMG_WIDTH;

  logic [7:0]        lb_r [0:LB_DEPTH-1];
  logic [7:0]        tap_s [0:3];
  logic [7:0]        win_r [0:3][0:3];
  logic signed [19:0] h_s [0:3];
  logic signed [19:0] h_r [0:3];
  logic signed [8:0]  vw_r [0:3];
  logic signed [31:0] v_s;
  logic signed [31:0] r_s;
  logic [7:0]        pix_s;
  logic [7:0]        pixel_out_r;
  logic [2:0]        valid_pipe_r;

  // Pixel is zero-extended; 20-bit wrap-around product is exact since the true result fits.
  function automatic logic signed [19:0] pix_mul(input logic signed [8:0] w, input logic [7:0] p);
    return $signed({{11{w[8]}}, w} * {12'd0, p});
  endfunction

  function automatic logic signed [31:0] h_mul(input logic signed [8:0] w, input logic signed [19:0] h);
    return $signed({{23{w[8]}}, w} * {{12{h[19]}}, h});
  endfunction

  // Row taps: tap0 is the live input, tapN the sample accepted N rows earlier.
  always_comb begin
    tap_s[0] = bus.din;
    tap_s[1] = lb_r[IMG_WIDTH-1];
    tap_s[2] = lb_r[2*IMG_WIDTH-1];
    tap_s[3] = lb_r[3*IMG_WIDTH-1];
  end

  // Line buffer and window advance only on accepted samples; window row 0 is the oldest row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < LB_DEPTH; j++) lb_r[j] <= 8'd0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) win_r[r][c] <= 8'd0;
    end else if (bus.ce) begin
      lb_r[0] <= bus.din;
      for (int j = 1; j < LB_DEPTH; j++) lb_r[j] <= lb_r[j-1];
      for (int r = 0; r < 4; r++) begin
        win_r[r][0] <= tap_s[3-r];
        for (int c = 1; c < 4; c++) win_r[r][c] <= win_r[r][c-1];
      end
    end else begin
      lb_r  <= lb_r;
      win_r <= win_r;
    end
  end

  // Horizontal MAC per row, column 3 being the oldest (leftmost) pixel.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      h_s[r] = pix_mul(bus.h_w0, win_r[r][3]) + pix_mul(bus.h_w1, win_r[r][2])
             + pix_mul(bus.h_w2, win_r[r][1]) + pix_mul(bus.h_w3, win_r[r][0]);
    end
  end

  // Vertical MAC, round half up at 2^14 and clamp into 0..255.
  always_comb begin
    v_s = h_mul(vw_r[0], h_r[0]) + h_mul(vw_r[1], h_r[1])
        + h_mul(vw_r[2], h_r[2]) + h_mul(vw_r[3], h_r[3]);
    r_s = (v_s + 32'sd8192) >>> 14;
    if (r_s < 32'sd0) begin
      pix_s = 8'd0;
    end else if (r_s > 32'sd255) begin
      pix_s = 8'd255;
    end else begin
      pix_s = r_s[7:0];
    end
  end

  // Stages 2 and 3 run every cycle; while ce is low they recompute from the held window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 4; r++) begin
        h_r[r]  <= 20'sd0;
        vw_r[r] <= 9'sd0;
      end
      pixel_out_r  <= 8'd0;
      valid_pipe_r <= 3'd0;
    end else begin
      h_r          <= h_s;
      vw_r[0]      <= bus.v_w0;
      vw_r[1]      <= bus.v_w1;
      vw_r[2]      <= bus.v_w2;
      vw_r[3]      <= bus.v_w3;
      pixel_out_r  <= pix_s;
      valid_pipe_r <= {valid_pipe_r[1:0], bus.ce};
    end
  end

  assign bus.pixel_out    = pixel_out_r;
  assign bus.output_valid = valid_pipe_r[2];

endmodule

// File: tb/tb_bicubic_lb_core.sv
// Directed bench for bicubic_lb_core with IMG_WIDTH=4 and hand-computed expectations.
module tb_bicubic_lb_core;

  logic clk;
  logic rst;
  int   chk_cnt;
  int   pass_cnt;

  bicubic_lb_if bus_if ();

  bicubic_lb_core #(.IMG_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  // Clock is held idle at first so reset can be checked before any edge.
  initial begin
    clk = 1'b0;
    #20;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input int observed, input int expected);
    chk_cnt++;
    if (observed == expected) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_w(input int h0, input int h1, input int h2, input int h3,
                       input int v0, input int v1, input int v2, input int v3);
    bus_if.h_w0 = 9'(h0); bus_if.h_w1 = 9'(h1); bus_if.h_w2 = 9'(h2); bus_if.h_w3 = 9'(h3);
    bus_if.v_w0 = 9'(v0); bus_if.v_w1 = 9'(v1); bus_if.v_w2 = 9'(v2); bus_if.v_w3 = 9'(v3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.ce = 1'b0;
    #1;
    step();
    rst = 1'b0;
  endtask

  task automatic stream(input int val, input int n);
    bus_if.din = 8'(val);
    bus_if.ce  = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  int ce_pat [0:7];
  int ov_exp [0:7];

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    rst = 1'b0;
    bus_if.ce  = 1'b0;
    bus_if.din = 8'd0;
    set_w(0, 128, 0, 0, 0, 128, 0, 0);

    // reset with clock idle
    #1 rst = 1'b1;
    #1;
    check_val("rst_idle_pix", int'(bus_if.pixel_out), 0);
    check_val("rst_idle_ov", int'(bus_if.output_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check_val("idle_pix", int'(bus_if.pixel_out), 0);
    check_val("idle_ov", int'(bus_if.output_valid), 0);

    // constant 100, centre-tap weights
    stream(100, 20);
    check_val("c100_pix", int'(bus_if.pixel_out), 100);
    check_val("c100_ov", int'(bus_if.output_valid), 1);

    // ce pattern 1,0,1,1,0 after draining the valid pipe
    bus_if.ce = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_val("drain_ov", int'(bus_if.output_valid), 0);
    ce_pat = '{1, 0, 1, 1, 0, 0, 0, 0};
    ov_exp = '{0, 0, 0, 1, 0, 1, 1, 0};
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("cepat_ov%0d", i), int'(bus_if.output_valid), ov_exp[i]);
      check_val($sformatf("cepat_pix%0d", i), int'(bus_if.pixel_out), 100);
      bus_if.ce = ce_pat[i][0];
      step();
    end

    // asynchronous reset mid-stream
    bus_if.ce = 1'b1;
    step();
    #2 rst = 1'b1;
    #1;
    check_val("rst_mid_pix", int'(bus_if.pixel_out), 0);
    check_val("rst_mid_ov", int'(bus_if.output_valid), 0);
    bus_if.ce = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_val("post_rst_ov", int'(bus_if.output_valid), 0);
    bus_if.ce = 1'b1;
    step();
    step();
    check_val("post_rst_ov_lat2", int'(bus_if.output_valid), 0);
    step();
    check_val("post_rst_ov_lat3", int'(bus_if.output_valid), 1);
    check_val("post_rst_tap_zero", int'(bus_if.pixel_out), 0);

    // constant 200 with a weight set summing to 128
    do_reset();
    set_w(-7, 108, 31, -4, -7, 108, 31, -4);
    stream(200, 24);
    check_val("c200_pix", int'(bus_if.pixel_out), 200);

    // clamp high then clamp low
    do_reset();
    set_w(0, 255, 0, 0, 0, 255, 0, 0);
    stream(255, 24);
    check_val("clamp_hi", int'(bus_if.pixel_out), 255);
    set_w(-128, 0, 0, 0, 128, 0, 0, 0);
    stream(255, 3);
    check_val("clamp_lo", int'(bus_if.pixel_out), 0);

    // single 64 impulse must appear exactly 15+2 edges later
    do_reset();
    set_w(128, 0, 0, 0, 128, 0, 0, 0);
    bus_if.din = 8'd64;
    bus_if.ce  = 1'b1;
    for (int j = 0; j < 25; j++) begin
      step();
      bus_if.din = 8'd0;
      check_val($sformatf("impulse_e%0d", j), int'(bus_if.pixel_out), (j == 17) ? 64 : 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
